// File: rtl/lfsr_seq_checker.sv
// Self-check stage for a 5-bit internal-XOR LFSR (x^5+x^2+1).
// Predicts each sample from the previous one, locks on a clean run and counts errors while locked.
module lfsr_seq_checker #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [4:0]       in_state,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap_pulse,
  output logic [4:0]       seq_pos
);

  localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);
  localparam logic [4:0] POS_LAST   = 5'd30;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_SYNC,
    ST_LOCKED
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] prev, prev_nxt;
  logic [3:0] match_cnt, match_nxt;
  logic [3:0] miss_cnt, miss_nxt;
  logic [4:0] pos_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic       err_hit;
  logic       wrap_nxt;
  logic       sample_ok;

  function automatic logic [4:0] predict(input logic [4:0] p);
    return {p[3], p[2], p[1] ^ p[4], p[0], p[4]};
  endfunction

  // An all-zero word is never accepted: a stuck source must not look healthy.
  assign sample_ok = (in_state == predict(prev)) && (in_state != 5'd0);

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    pos_nxt   = seq_pos;
    err_hit   = 1'b0;
    wrap_nxt  = 1'b0;

    if (in_valid) begin
      unique case (state)
        ST_EMPTY: begin
          if (in_state != 5'd0) begin
            prev_nxt  = in_state;
            match_nxt = 4'd0;
            state_nxt = ST_SYNC;
          end
        end
        ST_SYNC: begin
          prev_nxt = in_state;
          if (sample_ok) begin
            match_nxt = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_TGT) begin
              state_nxt = ST_LOCKED;
              pos_nxt   = 5'd0;
              miss_nxt  = 4'd0;
            end
          end else begin
            match_nxt = 4'd0;
          end
        end
        ST_LOCKED: begin
          // prev follows the received stream even on errors so one glitch costs one error.
          prev_nxt = in_state;
          if (seq_pos == POS_LAST) begin
            pos_nxt  = 5'd0;
            wrap_nxt = 1'b1;
          end else begin
            pos_nxt = seq_pos + 5'd1;
          end
          if (sample_ok) begin
            miss_nxt = 4'd0;
          end else begin
            err_hit  = 1'b1;
            miss_nxt = miss_cnt + 4'd1;
            if (miss_cnt + 4'd1 == UNLOCK_TGT) begin
              state_nxt = ST_SYNC;
              match_nxt = 4'd0;
            end
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end

    if (err_clr) begin
      err_nxt = err_hit ? ERR_W'(1) : '0;
    end else if (err_hit && (err_count != {ERR_W{1'b1}})) begin
      err_nxt = err_count + ERR_W'(1);
    end else begin
      err_nxt = err_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      prev       <= 5'd0;
      match_cnt  <= 4'd0;
      miss_cnt   <= 4'd0;
      seq_pos    <= 5'd0;
      err_count  <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      match_cnt  <= match_nxt;
      miss_cnt   <= miss_nxt;
      seq_pos    <= pos_nxt;
      err_count  <= err_nxt;
      locked     <= (state_nxt == ST_LOCKED);
      err_pulse  <= err_hit;
      wrap_pulse <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker: directed test-plan sequences followed by random streams.
module tb_lfsr_seq_checker;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_state = 5'd0;
  logic        err_clr = 1'b0;

  logic        locked_a, err_pulse_a, wrap_pulse_a;
  logic [15:0] err_count_a;
  logic [4:0]  seq_pos_a;
  logic        locked_b, err_pulse_b, wrap_pulse_b;
  logic [1:0]  err_count_b;
  logic [4:0]  seq_pos_b;

  lfsr_seq_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_state(in_state), .err_clr(err_clr),
    .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a),
    .wrap_pulse(wrap_pulse_a), .seq_pos(seq_pos_a)
  );

  lfsr_seq_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_state(in_state), .err_clr(err_clr),
    .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b),
    .wrap_pulse(wrap_pulse_b), .seq_pos(seq_pos_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit locked;
    bit err_pulse;
    int err_a;
    int err_b;
    bit wrap;
    int pos;
  } exp_t;

  exp_t exp_q[$];
  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: mode 0 = no previous sample, 1 = syncing, 2 = locked.
  int m_mode, m_prev, m_match, m_miss, m_pos, m_err_a, m_err_b;

  function automatic int nxt(input int p);
    int n;
    n = (p * 2) % 32;
    if (p >= 16) n = n ^ 5;
    return n;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_match = 0; m_miss = 0;
    m_pos = 0; m_err_a = 0; m_err_b = 0;
  endtask

  task automatic model_step(input bit v, input int s, input bit clr, output exp_t e);
    bit good, hit, wrap;
    hit = 0; wrap = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (s != 0) begin
          m_prev = s; m_match = 0; m_mode = 1;
        end
      end else begin
        good = (s == nxt(m_prev)) && (s != 0);
        m_prev = s;
        if (m_mode == 1) begin
          if (good) begin
            m_match++;
            if (m_match == LOCK_CNT) begin
              m_mode = 2; m_pos = 0; m_miss = 0;
            end
          end else begin
            m_match = 0;
          end
        end else begin
          wrap = (m_pos == 30);
          m_pos = (m_pos + 1) % 31;
          if (good) begin
            m_miss = 0;
          end else begin
            hit = 1;
            m_miss++;
            if (m_miss == UNLOCK_CNT) begin
              m_mode = 1; m_match = 0;
            end
          end
        end
      end
    end
    if (clr) begin
      m_err_a = hit ? 1 : 0;
      m_err_b = hit ? 1 : 0;
    end else if (hit) begin
      if (m_err_a < 65535) m_err_a++;
      if (m_err_b < 3) m_err_b++;
    end
    e.locked = (m_mode == 2); e.err_pulse = hit; e.err_a = m_err_a;
    e.err_b = m_err_b; e.wrap = wrap; e.pos = m_pos;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_output(input exp_t e);
    cmp("locked",       int'(locked_a),     int'(e.locked));
    cmp("err_pulse",    int'(err_pulse_a),  int'(e.err_pulse));
    cmp("err_count",    int'(err_count_a),  e.err_a);
    cmp("wrap_pulse",   int'(wrap_pulse_a), int'(e.wrap));
    cmp("seq_pos",      int'(seq_pos_a),    e.pos);
    cmp("sat_locked",   int'(locked_b),     int'(e.locked));
    cmp("sat_err_pulse", int'(err_pulse_b), int'(e.err_pulse));
    cmp("sat_err_count", int'(err_count_b), e.err_b);
  endtask

  task automatic check_reset_values(input string tag);
    exp_t e;
    e.locked = 0; e.err_pulse = 0; e.err_a = 0; e.err_b = 0; e.wrap = 0; e.pos = 0;
    cmp({tag, "_sat_pos"}, int'(seq_pos_b), 0);
    cmp({tag, "_sat_wrap"}, int'(wrap_pulse_b), 0);
    check_output(e);
  endtask

  task automatic apply_stimulus(input bit v, input int s, input bit clr);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_state = s[4:0];
    err_clr  = clr;
    model_step(v, s, clr, e);
    exp_q.push_back(e);
  endtask

  task automatic send_good(input bit clr);
    int s;
    if (m_mode == 0) s = $urandom_range(1, 31);
    else s = nxt(m_prev);
    apply_stimulus(1'b1, s, clr);
  endtask

  task automatic send_bad(input bit clr);
    apply_stimulus(1'b1, nxt(m_prev) ^ (1 << $urandom_range(0, 4)), clr);
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    err_clr  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expected response is retired after every clock edge that follows a stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    int first_stream[6];
    first_stream = '{1, 2, 4, 8, 16, 5};
    model_reset();

    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (first_stream[i]) apply_stimulus(1'b1, first_stream[i], 1'b0);
    repeat (31) send_good(1'b0);

    send_bad(1'b0);
    repeat (5) send_good(1'b0);

    repeat (3) send_bad(1'b0);
    repeat (6) send_good(1'b0);

    for (int i = 0; i < 10; i++) begin
      send_good(1'b0);
      repeat (1 + (i % 3)) apply_stimulus(1'b0, $urandom_range(0, 31), 1'b0);
    end

    for (int i = 0; i < 5; i++) begin
      send_bad(1'b0);
      send_good(1'b0);
    end
    send_bad(1'b1);
    send_good(1'b0);
    send_bad(1'b0);
    apply_stimulus(1'b0, 0, 1'b1);
    repeat (3) send_good(1'b0);

    mid_reset("locked_rst");

    repeat (20) apply_stimulus(1'b1, 0, 1'b0);
    mid_reset("zero_rst");

    for (int i = 0; i < 400; i++) begin
      int r;
      bit v, clr;
      r   = $urandom_range(0, 99);
      v   = ($urandom_range(0, 99) < 80);
      clr = ($urandom_range(0, 99) < 5);
      if (!v) apply_stimulus(1'b0, $urandom_range(0, 31), clr);
      else if (r < 85) send_good(clr);
      else if (r < 90) apply_stimulus(1'b1, 0, clr);
      else send_bad(clr);
    end

    @(negedge clk);
    in_valid = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(negedge clk);
    cmp("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
